cp0_exc: RTL and testbench

MEM-stage coprocessor-0 and exception unit of the five-stage MIPS pipeline. It sits at the output end of the EX/MEM pipeline register and reads what that register carries: the overflow flag, upstream exception code, instruction PC and instruction word. It holds Status, Cause, EPC, Count and Compare, and services mfc0, mtc0 and eret. It decides exception and interrupt entry, kills the faulting MEM instruction, then issues a one-cycle pipeline flush with a PC redirect.

---
 rtl/cp0_pkg.sv | 29 ++
 rtl/cp0_timer.sv | 48 ++++
 rtl/cp0_exc.sv | 182 ++++++++++++++++++
 tb/tb_cp0_exc.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register indices, exception codes, decode patterns and FSM states
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam logic [31:0] INS_ERET = 32'h4200_0018;
    localparam logic [10:0] PFX_MFC0 = 11'b010000_00000;
    localparam logic [10:0] PFX_MTC0 = 11'b010000_00100;

    localparam logic [31:0] STATUS_RST  = 32'h0000_0000;
    localparam logic [31:0] EPC_RST     = 32'h0000_0000;
    localparam logic [31:0] COUNT_RST   = 32'h0000_0000;
    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare registers with sticky timer-pending flag
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        pending
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        pending_q, pending_d;

    always_comb begin
        count_d   = wr_count ? wr_data : count_q + 32'd1;
        compare_d = wr_compare ? wr_data : compare_q;
        // A Compare write acknowledges the timer even if it coincides with a match
        if (wr_compare) begin
            pending_d = 1'b0;
        end else if (count_q == compare_q) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= COUNT_RST;
            compare_q <= COMPARE_RST;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pending_q <= pending_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign pending = pending_q;

endmodule

// File: rtl/cp0_exc.sv
// rtl/cp0_exc.sv - MEM-stage CP0 registers, exception/interrupt entry, eret and flush redirect
module cp0_exc
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_is_nop,
    input  logic        mem_overflow,
    input  logic [4:0]  mem_exccode,
    input  logic [31:0] mem_opc,
    input  logic [31:0] mem_ins,
    input  logic [31:0] mem_rt_data,
    input  logic [5:0]  hw_int,
    output logic        kill_mem,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] mfc0_data,
    output logic [31:0] status_out,
    output logic [31:0] cause_out,
    output logic [31:0] epc_out,
    output logic        exl
);

    state_e      state_q, state_d;
    logic        flush_q, flush_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;

    logic [31:0] count, compare;
    logic        timer_pending;

    logic        active, is_mtc0, is_eret, int_req;
    logic        take_exc, take_eret, wr_en;
    logic [4:0]  rd, exc_code;
    logic [5:0]  ip;

    // Bubbles and the flush cycle carry nothing that may act on CP0
    assign active  = !mem_is_nop && (state_q == RUN);
    assign rd      = mem_ins[15:11];
    assign is_mtc0 = (mem_ins[31:21] == PFX_MTC0);
    assign is_eret = (mem_ins == INS_ERET);
    assign ip      = {hw_int[5] | timer_pending, hw_int[4:0]};
    assign int_req = ie_q && !exl_q && (|(im_q[7:2] & ip));

    assign take_exc  = active && ((mem_exccode != 5'd0) || mem_overflow || int_req);
    assign take_eret = active && is_eret && !take_exc;
    assign wr_en     = active && is_mtc0 && !take_exc;
    assign kill_mem  = take_exc;

    always_comb begin
        if (mem_exccode != 5'd0) begin
            exc_code = mem_exccode;
        end else if (mem_overflow) begin
            exc_code = EXC_OV;
        end else begin
            exc_code = EXC_INT;
        end
    end

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .wr_count   (wr_en && (rd == CP0_COUNT)),
        .wr_compare (wr_en && (rd == CP0_COMPARE)),
        .wr_data    (mem_rt_data),
        .count      (count),
        .compare    (compare),
        .pending    (timer_pending)
    );

    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (take_exc) begin
            exccode_d = exc_code;
            // Nested entries keep the original return address
            if (!exl_q) begin
                epc_d = mem_opc;
                exl_d = 1'b1;
            end
        end else if (take_eret) begin
            exl_d = 1'b0;
        end else if (wr_en) begin
            case (rd)
                CP0_STATUS: begin
                    im_d  = mem_rt_data[15:8];
                    exl_d = mem_rt_data[1];
                    ie_d  = mem_rt_data[0];
                end
                CP0_EPC: epc_d = mem_rt_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_q      <= STATUS_RST[15:8];
            exl_q     <= STATUS_RST[1];
            ie_q      <= STATUS_RST[0];
            exccode_q <= 5'd0;
            epc_q     <= EPC_RST;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        case (state_q)
            RUN: begin
                if (take_exc) begin
                    state_d          = FLUSH;
                    flush_d          = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = EXC_VECTOR;
                end else if (take_eret) begin
                    state_d          = FLUSH;
                    flush_d          = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = epc_q;
                end
            end
            FLUSH: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= RUN;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            state_q          <= state_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

    assign status_out = {16'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_out  = {16'd0, ip, 3'd0, exccode_q, 2'd0};
    assign epc_out    = epc_q;
    assign exl        = exl_q;

    always_comb begin
        case (rd)
            CP0_COUNT:   mfc0_data = count;
            CP0_COMPARE: mfc0_data = compare;
            CP0_STATUS:  mfc0_data = status_out;
            CP0_CAUSE:   mfc0_data = cause_out;
            CP0_EPC:     mfc0_data = epc_out;
            default:     mfc0_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc.sv
// tb/tb_cp0_exc.sv - scoreboard bench for cp0_exc entry, eret, timer and reset behaviour
module tb_cp0_exc;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_is_nop;
    logic        mem_overflow;
    logic [4:0]  mem_exccode;
    logic [31:0] mem_opc;
    logic [31:0] mem_ins;
    logic [31:0] mem_rt_data;
    logic [5:0]  hw_int;
    logic        kill_mem;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mfc0_data;
    logic [31:0] status_out;
    logic [31:0] cause_out;
    logic [31:0] epc_out;
    logic        exl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [4:0]  code;
        logic        exl;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    localparam logic [31:0] VEC       = 32'h0000_4180;
    localparam logic [31:0] I_ERET    = 32'h4200_0018;
    localparam logic [31:0] I_MFC0_CNT = 32'h4000_4800;
    localparam logic [31:0] I_MFC0_CMP = 32'h4000_5800;
    localparam logic [31:0] I_MTC0_CNT = 32'h4080_4800;
    localparam logic [31:0] I_MTC0_CMP = 32'h4080_5800;
    localparam logic [31:0] I_MTC0_ST  = 32'h4080_6000;

    cp0_exc dut (
        .clk            (clk),
        .rst            (rst),
        .mem_is_nop     (mem_is_nop),
        .mem_overflow   (mem_overflow),
        .mem_exccode    (mem_exccode),
        .mem_opc        (mem_opc),
        .mem_ins        (mem_ins),
        .mem_rt_data    (mem_rt_data),
        .hw_int         (hw_int),
        .kill_mem       (kill_mem),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mfc0_data      (mfc0_data),
        .status_out     (status_out),
        .cause_out      (cause_out),
        .epc_out        (epc_out),
        .exl            (exl)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_is_nop   = 1'b1;
        mem_overflow = 1'b0;
        mem_exccode  = 5'd0;
        mem_opc      = 32'd0;
        mem_ins      = 32'd0;
        mem_rt_data  = 32'd0;
    endtask

    task automatic issue(input logic ovf, input logic [4:0] code, input logic [31:0] opc,
                         input logic [31:0] ins, input logic [31:0] rt);
        mem_is_nop   = 1'b0;
        mem_overflow = ovf;
        mem_exccode  = code;
        mem_opc      = opc;
        mem_ins      = ins;
        mem_rt_data  = rt;
        #1;
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] epc,
                                input logic [4:0] code, input logic x);
        exp_t e;
        e.pc   = pc;
        e.epc  = epc;
        e.code = code;
        e.exl  = x;
        exp_q.push_back(e);
    endtask

    // Called right after the detection edge: idles through FLUSH and confirms the pop
    task automatic finish_flush();
        idle();
        step();
        check("sb_drained", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (redirect_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_flush: got redirect_pc %h expected no flush", redirect_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("mon_flush", {31'd0, flush}, 32'd1);
                check("mon_redirect_pc", redirect_pc, mon_e.pc);
                check("mon_epc", epc_out, mon_e.epc);
                check("mon_exccode", {27'd0, cause_out[6:2]}, {27'd0, mon_e.code});
                check("mon_exl", {31'd0, exl}, {31'd0, mon_e.exl});
            end
        end
    end

    initial begin
        logic        found;
        logic [31:0] cnt;
        rst    = 1'b1;
        hw_int = 6'd0;
        idle();
        step();
        step();

        check("rst_status", status_out, 32'd0);
        check("rst_cause", cause_out, 32'd0);
        check("rst_epc", epc_out, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        mem_ins = I_MFC0_CMP;
        #1;
        check("rst_compare", mfc0_data, 32'hFFFF_FFFF);
        mem_ins = I_MFC0_CNT;
        #1;
        check("rst_count", mfc0_data, 32'd0);
        idle();
        rst = 1'b0;
        step();

        // Overflow entry, then an overflow arriving during FLUSH must be ignored
        issue(1'b1, 5'd0, 32'h0040_0010, 32'd0, 32'd0);
        check("ovf_kill", {31'd0, kill_mem}, 32'd1);
        expect_entry(VEC, 32'h0040_0010, 5'd12, 1'b1);
        step();
        issue(1'b1, 5'd0, 32'h0040_1234, 32'd0, 32'd0);
        check("flush_ignores_ins", {31'd0, kill_mem}, 32'd0);
        finish_flush();
        step();
        check("ovf_epc_kept", epc_out, 32'h0040_0010);
        check("ovf_exl", {31'd0, exl}, 32'd1);

        // eret back to EPC
        issue(1'b0, 5'd0, 32'h0000_4180, I_ERET, 32'd0);
        check("eret_kill", {31'd0, kill_mem}, 32'd0);
        expect_entry(32'h0040_0010, 32'h0040_0010, 5'd12, 1'b0);
        step();
        finish_flush();

        // Bubble carrying overflow
        mem_is_nop   = 1'b1;
        mem_overflow = 1'b1;
        #1;
        check("bubble_kill", {31'd0, kill_mem}, 32'd0);
        step();
        idle();
        step();
        check("bubble_no_flush", {31'd0, redirect_valid}, 32'd0);

        // Nested: syscall while EXL = 1 keeps EPC
        issue(1'b1, 5'd0, 32'h0040_0100, 32'd0, 32'd0);
        expect_entry(VEC, 32'h0040_0100, 5'd12, 1'b1);
        step();
        finish_flush();
        issue(1'b0, 5'd8, 32'h0040_0200, 32'd0, 32'd0);
        check("sys_kill", {31'd0, kill_mem}, 32'd1);
        expect_entry(VEC, 32'h0040_0100, 5'd8, 1'b1);
        step();
        finish_flush();
        issue(1'b0, 5'd0, 32'h0000_4180, I_ERET, 32'd0);
        expect_entry(32'h0040_0100, 32'h0040_0100, 5'd8, 1'b0);
        step();
        finish_flush();

        // Simultaneous exccode, overflow and unmasked interrupt
        issue(1'b0, 5'd0, 32'h0040_02F0, I_MTC0_ST, 32'h0000_0401);
        check("mtc0_st_kill", {31'd0, kill_mem}, 32'd0);
        step();
        idle();
        check("status_written", status_out, 32'h0000_0401);
        hw_int = 6'b000001;
        issue(1'b1, 5'd10, 32'h0040_0300, 32'd0, 32'd0);
        check("simul_kill", {31'd0, kill_mem}, 32'd1);
        expect_entry(VEC, 32'h0040_0300, 5'd10, 1'b1);
        step();
        finish_flush();
        hw_int = 6'd0;
        issue(1'b0, 5'd0, 32'h0000_4180, I_ERET, 32'd0);
        expect_entry(32'h0040_0300, 32'h0040_0300, 5'd10, 1'b0);
        step();
        finish_flush();

        // Interrupted mtc0 Status is killed and does not write
        hw_int = 6'b000001;
        issue(1'b0, 5'd0, 32'h0040_0400, I_MTC0_ST, 32'd0);
        check("int_mtc0_kill", {31'd0, kill_mem}, 32'd1);
        expect_entry(VEC, 32'h0040_0400, 5'd0, 1'b1);
        step();
        finish_flush();
        check("int_mtc0_no_write", status_out, 32'h0000_0403);
        check("int_cause_ip2", {31'd0, cause_out[10]}, 32'd1);
        hw_int = 6'd0;
        issue(1'b0, 5'd0, 32'h0040_0410, I_MTC0_ST, 32'd0);
        step();
        idle();
        check("status_cleared", status_out, 32'd0);

        // Reset asserted during FLUSH
        issue(1'b1, 5'd0, 32'h0040_0600, 32'd0, 32'd0);
        expect_entry(VEC, 32'h0040_0600, 5'd12, 1'b1);
        step();
        idle();
        rst = 1'b1;
        step();
        check("rstf_flush", {31'd0, flush}, 32'd0);
        check("rstf_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("rstf_redirect_pc", redirect_pc, 32'd0);
        check("rstf_status", status_out, 32'd0);
        check("rstf_cause", cause_out, 32'd0);
        check("rstf_epc", epc_out, 32'd0);
        mem_ins = I_MFC0_CMP;
        #1;
        check("rstf_compare", mfc0_data, 32'hFFFF_FFFF);
        check("rstf_sb", exp_q.size(), 0);
        idle();
        rst = 1'b0;

        // Timer interrupt at Count == Compare = 20
        issue(1'b0, 5'd0, 32'h0040_0700, I_MTC0_CMP, 32'd20);
        step();
        issue(1'b0, 5'd0, 32'h0040_0704, I_MTC0_ST, 32'h0000_8001);
        step();
        found = 1'b0;
        cnt   = 32'd0;
        for (int i = 0; i < 40; i++) begin
            issue(1'b0, 5'd0, 32'h0040_0500, I_MFC0_CNT, 32'd0);
            if (kill_mem) begin
                found = 1'b1;
                cnt   = mfc0_data;
                expect_entry(VEC, 32'h0040_0500, 5'd0, 1'b1);
                break;
            end
            step();
        end
        check("timer_entry_seen", {31'd0, found}, 32'd1);
        check("timer_entry_count", {31'd0, (cnt >= 32'd20) && (cnt <= 32'd21)}, 32'd1);
        step();
        finish_flush();
        check("timer_ip7_set", {31'd0, cause_out[15]}, 32'd1);
        issue(1'b0, 5'd0, 32'h0000_4180, I_MTC0_CMP, 32'd1000);
        step();
        idle();
        check("timer_ip7_clear", {31'd0, cause_out[15]}, 32'd0);

        // Count wraps
        issue(1'b0, 5'd0, 32'h0000_4184, I_MTC0_CNT, 32'hFFFF_FFFF);
        step();
        idle();
        mem_ins = I_MFC0_CNT;
        #1;
        check("count_max", mfc0_data, 32'hFFFF_FFFF);
        step();
        check("count_wrap", mfc0_data, 32'd0);
        idle();
        step();
        step();
        check("final_sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
